// File: rtl/mem_readback_engine_pkg.sv
// Shared app-interface types for the DDR3 read/write paths and the arbiter.
package mem_readback_engine_pkg;
  localparam int APP_ADDR_W = 29;
  localparam int BLOCK_W    = 256;

  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam logic [2:0] APP_CMD_READ  = 3'b001;

  typedef logic [APP_ADDR_W-1:0] app_addr_t;
  typedef logic [BLOCK_W-1:0]    block_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} rb_state_e;
endpackage

// File: rtl/mem_readback_engine_fifo.sv
// First-word-fall-through synchronous FIFO; writes into a full FIFO are dropped.
module sync_fifo_fwft #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  // Zero when empty so the stream reads clean out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/mem_readback_engine.sv
// Fetches a run of 256-bit blocks over the app interface and streams them out,
// credit-limiting outstanding reads against the return buffer.
module mem_readback_engine
  import mem_readback_engine_pkg::*;
#(
  parameter int ADDR_STRIDE = 8,
  parameter int FIFO_DEPTH  = 32,
  parameter int LEN_BITS    = 16
) (
  input  logic                clk_ram,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [28:0]         req_addr,
  input  logic [LEN_BITS-1:0] req_len,
  output logic                arb_req,
  input  logic                arb_grant,
  output logic [28:0]         app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  input  logic [255:0]        app_rd_data,
  input  logic                app_rd_data_valid,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [255:0]        rd_data,
  output logic                rd_last,
  output logic                busy,
  output logic                done,
  output logic                overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rb_state_e           state, state_nxt;
  app_addr_t           cur_addr;
  logic [LEN_BITS-1:0] cmd_left, beat_left;
  logic [CW-1:0]       outstanding, fifo_count;
  logic                out_of_rst, fifo_full, fifo_empty;
  logic                credit_ok, cmd_pending, accept, issue, pop;

  assign cmd_pending = cmd_left != '0;
  // Every in-flight read must already own a buffer slot.
  assign credit_ok   = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign accept      = req_valid && req_ready;
  assign issue       = app_en && app_rdy;
  assign rd_valid    = !fifo_empty;
  assign pop         = rd_valid && rd_ready;
  assign rd_last     = rd_valid && (beat_left == LEN_BITS'(1));
  assign app_addr    = cur_addr;
  assign app_cmd     = APP_CMD_READ;
  assign busy        = state != ST_IDLE;

  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      // cmd_left is only zero in ISSUE for a zero-length job.
      ST_ISSUE: if (!cmd_pending) state_nxt = ST_IDLE;
                else if (issue && cmd_left == LEN_BITS'(1)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop && rd_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    arb_req   = 1'b0;
    app_en    = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:  req_ready = out_of_rst;
      ST_ISSUE: begin
        arb_req = cmd_pending;
        app_en  = arb_grant && credit_ok && cmd_pending;
        done    = !cmd_pending;
      end
      ST_DRAIN: done = pop && rd_last;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      out_of_rst  <= 1'b0;
      cur_addr    <= '0;
      cmd_left    <= '0;
      beat_left   <= '0;
      outstanding <= '0;
      overflow    <= 1'b0;
    end else begin
      out_of_rst <= 1'b1;
      if (accept) begin
        cur_addr  <= req_addr;
        cmd_left  <= req_len;
        beat_left <= req_len;
      end else begin
        if (issue) begin
          cur_addr <= cur_addr + APP_ADDR_W'(ADDR_STRIDE);
          cmd_left <= cmd_left - LEN_BITS'(1);
        end
        if (pop) beat_left <= beat_left - LEN_BITS'(1);
      end
      case ({issue, app_rd_data_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase
      if (app_rd_data_valid && fifo_full) overflow <= 1'b1;
    end
  end

  sync_fifo_fwft #(.WIDTH(BLOCK_W), .DEPTH(FIFO_DEPTH)) u_ret_fifo (
    .clk     (clk_ram),
    .rst_n   (rst_n),
    .wr_en   (app_rd_data_valid),
    .wr_data (app_rd_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk_ram) disable iff (!rst_n)
    !(app_rd_data_valid && fifo_full));
  a_en_granted: assert property (@(posedge clk_ram) disable iff (!rst_n)
    app_en |-> arb_grant);
endmodule

// File: tb/tb_mem_readback_engine.sv
// Directed bench: app-interface responder with fixed 2-cycle read latency plus stream sink.
module tb_mem_readback_engine;
  logic         clk_ram = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_ready;
  logic [28:0]  req_addr = '0;
  logic [15:0]  req_len = '0;
  logic         arb_req, arb_grant = 1'b0;
  logic [28:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy = 1'b0;
  logic [255:0] app_rd_data = '0;
  logic         app_rd_data_valid = 1'b0;
  logic         rd_valid, rd_ready = 1'b0, rd_last;
  logic [255:0] rd_data;
  logic         busy, done, overflow;

  mem_readback_engine #(.ADDR_STRIDE(8), .FIFO_DEPTH(32), .LEN_BITS(16)) dut (
    .clk_ram(clk_ram), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .arb_req(arb_req), .arb_grant(arb_grant),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk_ram = ~clk_ram;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stimulus controls and observation logs
  int          cyc_n = 0, grant_mode = 0, rdy_mode = 0;
  logic        rst_ctl = 1'b0, sink_rdy = 1'b1, j_valid = 1'b0;
  logic [28:0] j_addr = '0;
  logic [15:0] j_len = '0;
  int          acc_cyc, done_cyc, done_cnt, busy_cnt, en_cnt, ret_cnt;
  int          grant_viol, hold_viol;
  logic        prev_stall = 1'b0;
  logic [28:0] prev_addr = '0;
  logic [28:0] cmd_q[$], pend_addr[$];
  int          cmd_cyc[$], pend_due[$];
  logic [255:0] beat_q[$];
  logic         beat_last[$];

  function automatic logic [255:0] blk(input logic [28:0] a);
    return {8{3'b000, a}};
  endfunction

  task automatic clr();
    acc_cyc = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0; en_cnt = 0; ret_cnt = 0;
    grant_viol = 0; hold_viol = 0;
    cmd_q.delete(); cmd_cyc.delete(); pend_addr.delete(); pend_due.delete();
    beat_q.delete(); beat_last.delete();
  endtask

  // Drive one cycle at the falling edge, then record what the next rising edge will see.
  task automatic cyc();
    @(negedge clk_ram);
    cyc_n++;
    rst_n     = rst_ctl;
    arb_grant = (grant_mode == 0) ? 1'b1 : ((cyc_n / 3) % 2 == 0);
    app_rdy   = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(1, 0));
    rd_ready  = sink_rdy;
    req_valid = j_valid;
    req_addr  = j_addr;
    req_len   = j_len;
    app_rd_data_valid = 1'b0;
    app_rd_data       = '0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc_n) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = blk(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
      ret_cnt++;
    end
    #1;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (app_en && !arb_grant) grant_viol++;
      if (prev_stall && arb_grant && (!app_en || app_addr !== prev_addr)) hold_viol++;
      prev_stall = app_en && !app_rdy;
      prev_addr  = app_addr;
      if (app_en) en_cnt++;
      if (app_en && app_rdy) begin
        cmd_q.push_back(app_addr);
        cmd_cyc.push_back(cyc_n);
        pend_addr.push_back(app_addr);
        pend_due.push_back(cyc_n + 2);
      end
      if (rd_valid && rd_ready) begin
        beat_q.push_back(rd_data);
        beat_last.push_back(rd_last);
      end
      if (done) begin done_cnt++; done_cyc = cyc_n; end
      if (busy) busy_cnt++;
      if (req_valid && req_ready) begin j_valid = 1'b0; acc_cyc = cyc_n; end
    end
  endtask

  task automatic run_job(input logic [28:0] a, input logic [15:0] n, input int budget);
    clr();
    j_addr = a; j_len = n; j_valid = 1'b1;
    for (int i = 0; i < budget && done_cnt == 0; i++) cyc();
    repeat (3) cyc();
  endtask

  task automatic check_job(input string t, input logic [28:0] a, input int n);
    logic [28:0] ea;
    int bad_addr, bad_data, lasts, last_pos;
    bad_addr = 0; bad_data = 0; lasts = 0; last_pos = -1;
    ea = a;
    for (int i = 0; i < n; i++) begin
      if (i >= cmd_q.size() || cmd_q[i] !== ea) bad_addr++;
      if (i >= beat_q.size() || beat_q[i] !== blk(ea)) bad_data++;
      ea = ea + 29'd8;
    end
    foreach (beat_last[i]) if (beat_last[i]) begin lasts++; last_pos = i; end
    chk({t, "_cmds"}, cmd_q.size(), n);
    chk({t, "_beats"}, beat_q.size(), n);
    chk({t, "_addr_seq"}, bad_addr, 0);
    chk({t, "_data"}, bad_data, 0);
    chk({t, "_last_cnt"}, lasts, (n > 0) ? 1 : 0);
    chk({t, "_last_pos"}, last_pos, n - 1);
    chk({t, "_done"}, done_cnt, 1);
    chk({t, "_overflow"}, overflow, 1'b0);
  endtask

  initial begin
    clr();
    // Reset values
    repeat (2) cyc();
    chk("rst_outs", {req_ready, arb_req, app_en, rd_valid, rd_last, busy, done, overflow}, 8'h00);
    chk("rst_cmd", app_cmd, 3'b001);
    chk("rst_addr", app_addr, 29'h0);
    chk("rst_data", rd_data, 256'h0);
    rst_ctl = 1'b1;
    cyc();
    cyc();
    chk("rst_ready_after", req_ready, 1'b1);

    // Basic 4-block job, full throughput
    run_job(29'h1000, 16'd4, 100);
    check_job("t1", 29'h1000, 4);
    chk("t1_first_cmd", (cmd_cyc.size() > 0) ? cmd_cyc[0] - acc_cyc : -1, 1);
    chk("t1_consec", (cmd_cyc.size() > 3) ? cmd_cyc[3] - cmd_cyc[0] : -1, 3);
    chk("t1_busy_low", busy, 1'b0);

    // Zero-length job
    run_job(29'h2000, 16'd0, 20);
    chk("t2_no_en", en_cnt, 0);
    chk("t2_done", done_cnt, 1);
    chk("t2_done_lat", done_cyc - acc_cyc, 1);
    chk("t2_busy_cycles", busy_cnt, 1);

    // Credit limit with stalled sink
    clr();
    sink_rdy = 1'b0; j_addr = 29'h8000; j_len = 16'd100; j_valid = 1'b1;
    repeat (80) cyc();
    chk("t3_cmd_cap", cmd_q.size(), 32);
    en_cnt = 0;
    repeat (10) cyc();
    chk("t3_en_quiet", en_cnt, 0);
    chk("t3_fifo_full_valid", rd_valid, 1'b1);
    sink_rdy = 1'b1;
    for (int i = 0; i < 1000 && done_cnt == 0; i++) cyc();
    repeat (3) cyc();
    check_job("t3", 29'h8000, 100);

    // Toggling grant, random app_rdy
    grant_mode = 1; rdy_mode = 1;
    run_job(29'h2000, 16'd20, 1500);
    check_job("t4", 29'h2000, 20);
    chk("t4_grant_viol", grant_viol, 0);
    chk("t4_hold_viol", hold_viol, 0);
    grant_mode = 0; rdy_mode = 0;

    // 29-bit address wrap
    run_job(29'h1FFF_FFF8, 16'd2, 100);
    check_job("t5", 29'h1FFF_FFF8, 2);
    chk("t5_wrap", (cmd_q.size() > 1) ? cmd_q[1] : 29'h1FFF_FFFF, 29'h0);

    // Reset mid-job with beats buffered
    clr();
    sink_rdy = 1'b0; j_addr = 29'h3000; j_len = 16'd10; j_valid = 1'b1;
    for (int i = 0; i < 50 && ret_cnt < 5; i++) cyc();
    cyc();
    chk("t6_buffered", rd_valid, 1'b1);
    rst_ctl = 1'b0;
    pend_addr.delete(); pend_due.delete();
    cyc();
    chk("t6_rst_outs", {req_ready, arb_req, app_en, rd_valid, rd_last, busy, done, overflow}, 8'h00);
    chk("t6_rst_addr", app_addr, 29'h0);
    chk("t6_rst_data", rd_data, 256'h0);
    repeat (2) cyc();
    rst_ctl = 1'b1;
    sink_rdy = 1'b1;
    repeat (2) cyc();
    run_job(29'h4000, 16'd1, 100);
    check_job("t6b", 29'h4000, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_readback_engine.md
Name: mem_readback_engine

Overview:
Read-side counterpart of the LA capture write path. It fetches a contiguous run of 256-bit blocks from DDR3 through the memory controller app interface and streams them to a client, such as the host upload path, with backpressure. It sits beside the memory arbiter on clk_ram. It requests the app command port through an arbiter req/grant pair, and credit-limits outstanding reads so that app_rd_data, which cannot be stalled, never overflows its local buffer.

Parameters:
ADDR_STRIDE, 8, app_addr increment per 256-bit read command
FIFO_DEPTH, 32, entries in the return buffer (power of 2, at least 4)
LEN_BITS, 16, width of the request length field, in blocks

Ports:
clk_ram  in  1  controller UI clock, all logic on its rising edge
rst_n  in  1  async active-low reset
req_valid  in  1  read job request
req_ready  out  1  engine idle and accepting a job
req_addr  in  29  start app_addr (must be ADDR_STRIDE aligned)
req_len  in  LEN_BITS  number of 256-bit blocks to read
arb_req  out  1  request ownership of the app command port
arb_grant  in  1  arbiter grant; app_en may be high only while this is high
app_addr  out  29  command address
app_cmd  out  3  always 3'b001 (read)
app_en  out  1  command strobe
app_rdy  in  1  controller accepts the command when app_en && app_rdy
app_rd_data  in  256  read return data
app_rd_data_valid  in  1  return beat valid
rd_valid  out  1  output stream valid
rd_ready  in  1  output stream ready
rd_data  out  256  output data
rd_last  out  1  final beat of the job
busy  out  1  job in progress
done  out  1  one-cycle pulse when the last beat is consumed
overflow  out  1  sticky: a return beat arrived while the FIFO was full

Behaviour:
- Reset values: req_ready=0 during reset and 1 on the first cycle after it. All other outputs are 0, with app_cmd=3'b001.
- Job acceptance: req_valid && req_ready latches cur_addr=req_addr, cmd_left=req_len, beat_left=req_len. State goes IDLE->ISSUE.
- req_len=0: accepted, no commands issued, no beats produced. done pulses on the next cycle and state returns to IDLE.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: req_ready=1, arb_req=0.
- ISSUE: arb_req=1 while cmd_left!=0.
  - app_en = arb_grant && credit_ok && cmd_left!=0.
  - credit_ok = (outstanding + fifo_count) < FIFO_DEPTH.
  - A command counts as issued when app_en && app_rdy. On issue: cur_addr += ADDR_STRIDE (29-bit wrap), cmd_left--, outstanding++.
  - app_en and app_addr hold stable until accepted. app_en drops if grant drops.
  - When the last command is issued, state goes to DRAIN and arb_req falls in the same cycle as that issue.
- Return path: each app_rd_data_valid writes one FIFO entry and decrements outstanding. A simultaneous issue and return leaves outstanding unchanged.
- Return into a full FIFO: the beat is dropped and overflow is set. This cannot occur under correct crediting and is an assertion target.
- Output: first-word-fall-through. rd_valid = FIFO non-empty. A beat pops when rd_valid && rd_ready, which decrements beat_left. rd_last = rd_valid && beat_left==1.
- rd_data must be stable while rd_valid && !rd_ready.
- DRAIN: when the last beat pops, done pulses for 1 cycle, busy drops next cycle, and state goes to IDLE.
- Throughput: with rd_ready=1, arb_grant=1 and app_rdy=1, the engine sustains 1 command/cycle. Latency from app_rd_data_valid to rd_valid is 1 cycle.
- Counter widths: outstanding and fifo_count are log2(FIFO_DEPTH)+1 bits. cmd_left and beat_left are LEN_BITS.
- busy = state!=IDLE.
- overflow clears only on reset.
- Reset mid-job: everything returns to reset values immediately. Any read returns still in flight in the controller are the system's responsibility; the engine is reset only while the controller is idle or itself in reset.

Decomposition:
- Shared mem package: APP_CMD_READ/APP_CMD_WRITE constants, a 29-bit app address typedef, and a 256-bit block typedef. The arbiter reuses all three.
- Sub-module sync_fifo_fwft, parameterised width and depth, exposing count, full and empty. Instantiated once as the return buffer.

Test Plan:
- req_addr=0x1000, req_len=4, ready/grant/rdy all 1, read returns 2 cycles after accept -> app_addr 0x1000,0x1008,0x1010,0x1018 on consecutive cycles; 4 rd beats in order; rd_last on beat 4; one done pulse.
- req_len=0 -> no app_en; done pulses one cycle after accept; busy high exactly 1 cycle.
- req_len=100, rd_ready=0 throughout -> exactly 32 commands issued, then app_en stays 0. Release rd_ready -> all 100 beats delivered and overflow remains 0.
- arb_grant toggles every 3 cycles, app_rdy random at 50% -> app_en never high without grant; app_addr held while unaccepted; all addresses sequential with none duplicated.
- req_addr=0x1FFF_FFF8, req_len=2 -> second app_addr is 0x0000_0000 (29-bit wrap).
- Assert rst_n low mid-job with 5 beats buffered -> all outputs return to reset values, and a following len=1 job completes normally.
